// File: rtl/pipelined_chunk_adder.sv
// pipelined_chunk_adder
//   WIDTH-bit add with carry-in, cut into CHUNK-bit slices, one slice per
//   pipeline stage (STAGES = WIDTH/CHUNK). The carry is registered between
//   stages; the operand bits not yet added ride along in skew registers.
//   Fully pipelined with valid/ready handshakes on both sides.
//
//   Optional macro PIPELINED_CHUNK_ADDER_SUB_EN adds a 'sub' input that turns
//   the operation into a - b (a + ~b + 1).
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   input handshake (in_ready = !stall)
//   a, b, carry_in      operands and carry into bit 0
//   sub                 subtract select (only with PIPELINED_CHUNK_ADDER_SUB_EN)
//   out_valid/out_ready output handshake
//   sum, carry_out      result bits and carry out of the MSB
//   overflow            signed two's-complement overflow
module pipelined_chunk_adder #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             carry_in,
`ifdef PIPELINED_CHUNK_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out,
   output logic             overflow
);

   // Guarded so a zero CHUNK reaches the elaboration error instead of a divide by zero.
   localparam int STAGES = (CHUNK < 1) ? 1 : WIDTH / CHUNK;

   if (CHUNK < 1) begin : g_err_chunk
      $fatal(1, "pipelined_chunk_adder: CHUNK must be >= 1");
   end else if (WIDTH % CHUNK != 0) begin : g_err_width
      $fatal(1, "pipelined_chunk_adder: WIDTH must be a multiple of CHUNK");
   end

   logic             stall;
   logic [WIDTH-1:0] b_eff;
   logic             cin0;
   logic [STAGES-1:0] vld_q;

   // The whole pipeline freezes while the result is waiting on downstream.
   assign stall    = out_valid && !out_ready;
   assign in_ready = !stall;

`ifdef PIPELINED_CHUNK_ADDER_SUB_EN
   // Complement is folded into the operand mux, so the skew registers already
   // hold ~b and the sign bit carried for overflow is the inverted b sign.
   assign b_eff = sub ? ~b : b;
   assign cin0  = sub ? 1'b1 : carry_in;
`else
   assign b_eff = b;
   assign cin0  = carry_in;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= '0;
      end else if (!stall) begin
         vld_q[0] <= in_valid;
         for (int k = 1; k < STAGES; k++) vld_q[k] <= vld_q[k-1];
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stg
      localparam int LO  = k * CHUNK;    // sum bits already completed on entry
      localparam int REM = WIDTH - LO;   // operand bits still to add on entry

      logic [REM-1:0]        a_in, b_in;
      logic                  cin, sa_in, sb_in;
      logic [LO+CHUNK-1:0]   sum_d, sum_q;
      logic                  c_d, c_q;
      logic                  sa_q, sb_q;

      if (k == 0) begin : g_first
         assign a_in  = a;
         assign b_in  = b_eff;
         assign cin   = cin0;
         assign sa_in = a[WIDTH-1];
         assign sb_in = b_eff[WIDTH-1];
         assign {c_d, sum_d} = {1'b0, a_in[CHUNK-1:0]} + {1'b0, b_in[CHUNK-1:0]}
                             + {{CHUNK{1'b0}}, cin};
      end else begin : g_next
         logic [CHUNK-1:0] chunk;
         assign a_in  = g_stg[k-1].g_skew.a_q;
         assign b_in  = g_stg[k-1].g_skew.b_q;
         assign cin   = g_stg[k-1].c_q;
         assign sa_in = g_stg[k-1].sa_q;
         assign sb_in = g_stg[k-1].sb_q;
         assign {c_d, chunk} = {1'b0, a_in[CHUNK-1:0]} + {1'b0, b_in[CHUNK-1:0]}
                             + {{CHUNK{1'b0}}, cin};
         assign sum_d = {chunk, g_stg[k-1].sum_q};
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            sum_q <= '0;
            c_q   <= 1'b0;
            sa_q  <= 1'b0;
            sb_q  <= 1'b0;
         end else if (!stall) begin
            sum_q <= sum_d;
            c_q   <= c_d;
            sa_q  <= sa_in;
            sb_q  <= sb_in;
         end
      end

      // Upper operand slices that later stages still need.
      if (REM > CHUNK) begin : g_skew
         logic [REM-CHUNK-1:0] a_q, b_q;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               a_q <= '0;
               b_q <= '0;
            end else if (!stall) begin
               a_q <= a_in[REM-1:CHUNK];
               b_q <= b_in[REM-1:CHUNK];
            end
         end
      end
   end

   assign out_valid = vld_q[STAGES-1];
   assign sum       = g_stg[STAGES-1].sum_q;
   assign carry_out = g_stg[STAGES-1].c_q;
   // All-zero registers give overflow=0, so reset state needs no special case.
   assign overflow  = (g_stg[STAGES-1].sa_q == g_stg[STAGES-1].sb_q) &&
                      (g_stg[STAGES-1].sum_q[WIDTH-1] != g_stg[STAGES-1].sa_q);

endmodule

// File: tb/tb_pipelined_chunk_adder.sv
module tb_pipelined_chunk_adder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, carry_in, sub, out_valid, out_ready, carry_out, overflow;
   logic [31:0] a, b, sum;
   logic        in_valid1, in_ready1, cin1, sub1, out_valid1, out_ready1, co1, ov1;
   logic [15:0] a1, b1, sum1;

   int n_err = 0;
   int n_chk = 0;

   logic [31:0] op_a [10];
   logic [31:0] op_b [10];
   logic        op_c [10];
   logic        op_s [10];

   always #5 clk = ~clk;

   pipelined_chunk_adder #(.WIDTH(32), .CHUNK(8)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .carry_in(carry_in),
`ifdef PIPELINED_CHUNK_ADDER_SUB_EN
      .sub(sub),
`endif
      .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
      .carry_out(carry_out), .overflow(overflow)
   );

   pipelined_chunk_adder #(.WIDTH(16), .CHUNK(16)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
      .a(a1), .b(b1), .carry_in(cin1),
`ifdef PIPELINED_CHUNK_ADDER_SUB_EN
      .sub(sub1),
`endif
      .out_valid(out_valid1), .out_ready(out_ready1), .sum(sum1),
      .carry_out(co1), .overflow(ov1)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, want %h", tag, act, exp);
      end
   endtask

   // Reference: plain full-width add, {overflow, carry_out, sum}.
   function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y,
                                         input logic ci, input logic s);
      logic [31:0] yy;
      logic [32:0] r;
      yy = s ? ~y : y;
      r  = {1'b0, x} + {1'b0, yy} + {32'd0, (s ? 1'b1 : ci)};
      return {(x[31] == yy[31]) && (r[31] != x[31]), r};
   endfunction

   // Called at a drive point (1 time unit after a rising edge).
   task automatic lat_test(input string tag, input logic [31:0] xa, input logic [31:0] xb,
                           input logic xc, input logic xs,
                           input logic [31:0] es, input logic eco, input logic eov);
      in_valid = 1'b1; a = xa; b = xb; carry_in = xc; sub = xs;
      for (int i = 1; i <= 4; i++) begin
         @(posedge clk); #1;
         in_valid = 1'b0;
         #1;
         check({tag, "_vld"}, {31'd0, out_valid}, {31'd0, i == 4});
      end
      check({tag, "_sum"}, sum, es);
      check({tag, "_co"}, {31'd0, carry_out}, {31'd0, eco});
      check({tag, "_ov"}, {31'd0, overflow}, {31'd0, eov});
      @(posedge clk); #1;
   endtask

   task automatic lat1_test(input string tag, input logic [15:0] xa, input logic [15:0] xb,
                            input logic xs, input logic [15:0] es, input logic eco,
                            input logic eov);
      in_valid1 = 1'b1; a1 = xa; b1 = xb; cin1 = 1'b0; sub1 = xs;
      @(posedge clk); #1;
      in_valid1 = 1'b0;
      #1;
      check({tag, "_vld"}, {31'd0, out_valid1}, 32'd1);
      check({tag, "_sum"}, {16'd0, sum1}, {16'd0, es});
      check({tag, "_co"}, {31'd0, co1}, {31'd0, eco});
      check({tag, "_ov"}, {31'd0, ov1}, {31'd0, eov});
      @(posedge clk); #2;
      check({tag, "_drain"}, {31'd0, out_valid1}, 32'd0);
      @(posedge clk); #1;
   endtask

   // Ten back-to-back accepts; results must appear on ten consecutive cycles.
   task automatic run_stream(input string tag);
      logic [33:0] e;
      for (int t = 0; t < 14; t++) begin
         if (t < 10) begin
            in_valid = 1'b1; a = op_a[t]; b = op_b[t]; carry_in = op_c[t]; sub = op_s[t];
         end else begin
            in_valid = 1'b0;
         end
         #1;
         check({tag, "_vld"}, {31'd0, out_valid}, {31'd0, t >= 4});
         if (t >= 4) begin
            e = model(op_a[t-4], op_b[t-4], op_c[t-4], op_s[t-4]);
            check({tag, "_sum"}, sum, e[31:0]);
            check({tag, "_co"}, {31'd0, carry_out}, {31'd0, e[32]});
            check({tag, "_ov"}, {31'd0, overflow}, {31'd0, e[33]});
         end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      logic [33:0] e;
      int idx;
      rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; carry_in = 1'b0; sub = 1'b0;
      out_ready = 1'b1;
      in_valid1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; sub1 = 1'b0; out_ready1 = 1'b1;
      #12;
      check("reset_vld", {31'd0, out_valid}, 32'd0);
      check("reset_sum", sum, 32'd0);
      check("reset_co", {31'd0, carry_out}, 32'd0);
      check("reset_ov", {31'd0, overflow}, 32'd0);
      check("reset_rdy", {31'd0, in_ready}, 32'd1);
      check("reset_vld1", {31'd0, out_valid1}, 32'd0);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      lat_test("basic", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
      lat_test("chain", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
      lat_test("sovf",  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
      lat_test("negovf", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1);

      op_a = '{32'h1234_5678, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_FFFF,
               32'hDEAD_BEEF, 32'h00FF_00FF, 32'hA5A5_A5A5, 32'h0101_0101, 32'hCAFE_BABE};
      op_b = '{32'h1111_1111, 32'h0000_0001, 32'h8000_0000, 32'h0000_0000, 32'h0000_FFFF,
               32'h2152_4110, 32'hFF00_FF00, 32'h5A5A_5A5A, 32'h0202_0202, 32'h1357_9BDF};
      op_c = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      op_s = '{default: 1'b0};
      run_stream("stream");

      // Backpressure: stall 3 cycles with the pipe full and a fifth op waiting.
      for (int t = 0; t < 13; t++) begin
         out_ready = !(t >= 4 && t <= 6);
         in_valid  = (t <= 7);
         idx = (t < 4) ? t : 4;
         a = op_a[idx]; b = op_b[idx]; carry_in = op_c[idx]; sub = 1'b0;
         #1;
         check("bp_rdy", {31'd0, in_ready}, {31'd0, !(t >= 4 && t <= 6)});
         if (t < 4 || t == 12) begin
            check("bp_vld", {31'd0, out_valid}, 32'd0);
         end else begin
            idx = (t <= 7) ? 0 : t - 7;
            e = model(op_a[idx], op_b[idx], op_c[idx], 1'b0);
            check("bp_vld", {31'd0, out_valid}, 32'd1);
            check("bp_sum", sum, e[31:0]);
            check("bp_co", {31'd0, carry_out}, {31'd0, e[32]});
         end
         @(posedge clk); #1;
      end
      out_ready = 1'b1;

      // Reset with one result at the output and three more behind it.
      for (int t = 0; t < 4; t++) begin
         in_valid = 1'b1; a = op_a[t]; b = op_b[t]; carry_in = op_c[t];
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      #1;
      check("rst_pre_vld", {31'd0, out_valid}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("rst_vld", {31'd0, out_valid}, 32'd0);
      check("rst_sum", sum, 32'd0);
      check("rst_co", {31'd0, carry_out}, 32'd0);
      check("rst_ov", {31'd0, overflow}, 32'd0);
      check("rst_rdy", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #2;
      rst_n = 1'b1;
      for (int t = 0; t < 8; t++) begin
         @(posedge clk); #1;
         check("rst_stale", {31'd0, out_valid}, 32'd0);
      end
      lat_test("post_rst", 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, 32'h0000_0003, 1'b0, 1'b0);

      lat1_test("w16", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
      lat1_test("w16ovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);

`ifdef PIPELINED_CHUNK_ADDER_SUB_EN
      lat_test("sub57", 32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
      lat1_test("w16sub", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
      op_a = '{32'd10, 32'd10, 32'd0, 32'h8000_0000, 32'h7FFF_FFFF,
               32'h1234_5678, 32'hFFFF_FFFF, 32'h0000_0100, 32'h8000_0000, 32'hCAFE_BABE};
      op_b = '{32'd3, 32'd3, 32'd1, 32'd1, 32'hFFFF_FFFF,
               32'h1234_5678, 32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 32'h1357_9BDF};
      op_c = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      op_s = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      run_stream("mixed");
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
